// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one 32-bit adder (4-bit CLA groups, rippled) among
// NUM_REQ requesters, with a one-deep registered response slot and multi-word carry chaining.
module adder_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_REQ-1:0]      req_valid_in,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*32-1:0]   req_a_in,
    input  logic [NUM_REQ*32-1:0]   req_b_in,
    input  logic [NUM_REQ-1:0]      req_c_in,
    input  logic [NUM_REQ-1:0]      req_last_in,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_in,
    output logic [ID_W-1:0]         resp_id_o,
    output logic [31:0]             resp_sum_o,
    output logic                    resp_c_o,
    output logic                    resp_last_o
);

    localparam int unsigned NREQ = NUM_REQ;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr, lock_owner, grant_idx, cand;
    logic            carry_reg, slot_free, grant_vld, locked;
    logic [31:0]     op_a, op_b, sum;
    logic            cin, cout, beat_last;
    int unsigned     idx;

    assign locked    = (state_q == LOCKED);
    assign slot_free = !resp_valid_o || resp_ready_in;

    always_comb begin
        grant_vld   = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        idx         = 0;
        req_ready_o = '0;
        if (!rst_in && slot_free) begin
            if (locked) begin
                grant_idx = lock_owner;
                grant_vld = req_valid_in[lock_owner];
            end else begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    idx = 32'(rr_ptr) + i;
                    if (idx >= NREQ) idx = idx - NREQ;
                    cand = ID_W'(idx);
                    if (!grant_vld && req_valid_in[cand]) begin
                        grant_vld = 1'b1;
                        grant_idx = cand;
                    end
                end
            end
        end
        if (grant_vld) req_ready_o[grant_idx] = 1'b1;
    end

    assign op_a      = req_a_in[32*grant_idx +: 32];
    assign op_b      = req_b_in[32*grant_idx +: 32];
    assign cin       = locked ? carry_reg : req_c_in[grant_idx];
    assign beat_last = req_last_in[grant_idx];

    // Eight 4-bit lookahead groups; group carry-out ripples into the next group.
    always_comb begin : cla
        logic [3:0] gp, gg;
        logic [4:0] gc;
        logic [8:0] grp_c;
        gp       = '0;
        gg       = '0;
        gc       = '0;
        grp_c    = '0;
        sum      = '0;
        grp_c[0] = cin;
        for (int unsigned k = 0; k < 8; k++) begin
            gp    = op_a[4*k +: 4] ^ op_b[4*k +: 4];
            gg    = op_a[4*k +: 4] & op_b[4*k +: 4];
            gc[0] = grp_c[k];
            gc[1] = gg[0] | (gp[0] & gc[0]);
            gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
            gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                  | (gp[2] & gp[1] & gp[0] & gc[0]);
            gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                  | (gp[3] & gp[2] & gp[1] & gg[0])
                  | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);
            sum[4*k +: 4] = gp ^ gc[3:0];
            grp_c[k+1]    = gc[4];
        end
        cout = grp_c[8];
    end

    always_comb begin
        state_d = state_q;
        if (grant_vld) state_d = beat_last ? IDLE : LOCKED;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            resp_valid_o <= 1'b0;
            resp_id_o    <= '0;
            resp_sum_o   <= '0;
            resp_c_o     <= 1'b0;
            resp_last_o  <= 1'b0;
            rr_ptr       <= '0;
            lock_owner   <= '0;
            carry_reg    <= 1'b0;
        end else if (grant_vld) begin
            resp_valid_o <= 1'b1;
            resp_id_o    <= grant_idx;
            resp_sum_o   <= sum;
            resp_c_o     <= cout;
            resp_last_o  <= beat_last;
            carry_reg    <= cout;
            if (!beat_last)
                lock_owner <= grant_idx;
            else
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (resp_ready_in) begin
            resp_valid_o <= 1'b0;
        end
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one 32-bit adder (4-bit CLA groups, ripple between groups) among NUM_REQ requesters.
- Round-robin arbitration; result held in a one-deep registered response slot with valid/ready handshake.
- Supports multi-word (chained) additions: a requester holding the lock gets the stored carry-out as carry-in on its next beat, so wider operands are added one 32-bit word per beat, LSW first.
- Sits between requester engines and the shared adder datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of resp_id_o; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  synchronous reset, active-high
req_valid_in  input  NUM_REQ  per-requester request valid
req_ready_o  output  NUM_REQ  per-requester accept, one-hot or zero
req_a_in  input  NUM_REQ*32  operand A, requester i at [32*i+31:32*i]
req_b_in  input  NUM_REQ*32  operand B, same packing
req_c_in  input  NUM_REQ  carry-in, used only on first beat of a chain
req_last_in  input  NUM_REQ  1 = final beat of operation, 0 = more beats follow
resp_valid_o  output  1  response slot full
resp_ready_in  input  1  consumer accepts response
resp_id_o  output  ID_W  index of requester that produced result
resp_sum_o  output  32  sum word
resp_c_o  output  1  carry-out of this beat
resp_last_o  output  1  copy of req_last_in of this beat

Behaviour:
- Single clock domain. rst_in is synchronous and active-high.
- Reset values:
  - resp_valid_o=0, resp_id_o=0, resp_sum_o=0, resp_c_o=0, resp_last_o=0.
  - rr_ptr=0, locked=0, lock_owner=0, carry_reg=0.
  - req_ready_o=0 during the reset cycle.
- Slot free: slot_free = !resp_valid_o || resp_ready_in (combinational).
- Arbitration (combinational, every cycle):
  - If !slot_free: grant none.
  - Else if locked: grant lock_owner only if req_valid_in[lock_owner]; all others ready=0 even if valid.
  - Else: grant the first valid requester searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready_o[g]=1 only for the granted index.
- Adder inputs:
  - a = req_a_in[g], b = req_b_in[g].
  - cin = locked ? carry_reg : req_c_in[g].
- Transfer on granted valid&ready (edge):
  - resp_sum_o <= sum, resp_c_o <= cout, resp_id_o <= g, resp_last_o <= req_last_in[g], resp_valid_o <= 1, carry_reg <= cout.
  - If req_last_in[g]=0: locked <= 1, lock_owner <= g, rr_ptr unchanged.
  - If req_last_in[g]=1: locked <= 0, rr_ptr <= (g+1) mod NUM_REQ.
- No transfer and resp_ready_in=1: resp_valid_o <= 0; data fields hold last values.
- No transfer and resp_ready_in=0: all response fields hold (stable while valid).
- Latency and throughput:
  - Latency is 1 cycle from accepted request to resp_valid_o.
  - Throughput is 1 beat/cycle while resp_ready_in=1 (simultaneous drain and refill allowed).
- FSM (2 states, encoded by `locked`):
  - IDLE -> IDLE on last=1 beat.
  - IDLE -> LOCKED on last=0 beat.
  - LOCKED -> LOCKED on last=0 beat.
  - LOCKED -> IDLE on last=1 beat.
  - Owner deasserting valid while LOCKED: the lock is kept and the owner waits; no timeout.
- Edge cases:
  - Single-beat op: last=1 on first beat; req_c_in is used.
  - Wrap-around: rr_ptr=NUM_REQ-1 with grant to NUM_REQ-1 sets rr_ptr to 0.
  - Carry out of bit 31 of the final beat appears on resp_c_o; no overflow flag.
- Reset mid-chain: lock and carry_reg cleared, pending response dropped. The requester must restart the operation from its first beat.
- Inputs of a non-granted requester are ignored and must be held by the requester until ready.

Test Plan:
1. Reset then idle -> all outputs 0, req_ready_o=0; then req 0 only with a=0x00000005, b=0x00000003, c=1, last=1 -> next cycle resp_valid_o=1, sum=0x00000009, c=0, id=0, last=1.
2. All 4 valid, single-beat, resp_ready_in=1 constantly -> grants in order 0,1,2,3,0 on consecutive cycles; one response per cycle, ids match.
3. 64-bit chain on req 1:
   - Beat0: a=0xFFFFFFFF, b=0x00000001, c=0, last=0 -> sum=0x00000000, c=1.
   - Beat1: a=0x00000000, b=0x00000000, c_in=0 (ignored), last=1 -> sum=0x00000001, c=0.
   - Req 0 valid throughout gets ready=0 until beat1 accepted, then granted next.
4. Backpressure: resp_ready_in=0 after one accepted request -> resp_* stable for 5 cycles, all req_ready_o=0. Raise resp_ready_in -> a new grant occurs in the same cycle.
5. Overflow: a=0x80000000, b=0x80000000, c=0, last=1 -> sum=0x00000000, c=1.
6. rst_in asserted between beats of a locked chain on req 2 -> after reset, locked=0, resp_valid_o=0. Req 3 single-beat is granted next with its own req_c_in.
